// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage: datapath widths, the fetch
// state encoding and the address-alignment helper.
package instr_fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DONE  = 2'd2,
        FETCH_FAULT = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-memory read per fetch request,
// handles branch redirects in every state and latches a sticky fault.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0,
    parameter int              TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [ILEN-1:0] instruction,
    output logic            load_ir,
    output logic [XLEN-1:0] instr_pc,
    output logic            busy,
    output logic            fault
);

    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state_r;
    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  pend_pc_r;
    logic             pend_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             bad_target_s;
    logic             redirect_s;
    logic [XLEN-1:0]  redirect_pc_s;

    // Redirect decode: a same-cycle pc_load wins over an older pending one.
    always_comb begin
        bad_target_s  = 1'b0;
        redirect_s    = pend_r;
        redirect_pc_s = pend_pc_r;
        if (pc_load) begin
            bad_target_s  = !is_word_aligned(pc_target);
            redirect_s    = 1'b1;
            redirect_pc_s = pc_target;
        end else begin
            bad_target_s  = 1'b0;
        end
    end

    // Busy decodes straight from the state register.
    always_comb begin
        busy = (state_r != FETCH_IDLE);
    end

    // Fetch FSM with PC, capture registers and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= FETCH_IDLE;
            pc_r        <= RESET_PC;
            pend_pc_r   <= '0;
            pend_r      <= 1'b0;
            wait_cnt_r  <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instruction <= '0;
            instr_pc    <= '0;
            load_ir     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state_r)
                FETCH_IDLE: begin
                    load_ir <= 1'b0;
                    if (bad_target_s) begin
                        fault   <= 1'b1;
                        state_r <= FETCH_FAULT;
                    end else if (pc_load) begin
                        pc_r <= pc_target;
                        if (fetch_req) begin
                            state_r    <= FETCH_REQ;
                            imem_req   <= 1'b1;
                            imem_addr  <= pc_target;
                            wait_cnt_r <= '0;
                        end
                    end else if (fetch_req) begin
                        state_r    <= FETCH_REQ;
                        imem_req   <= 1'b1;
                        imem_addr  <= pc_r;
                        wait_cnt_r <= '0;
                    end
                end
                FETCH_REQ: begin
                    if (bad_target_s) begin
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                        pend_r   <= 1'b0;
                        state_r  <= FETCH_FAULT;
                    end else if (imem_ack) begin
                        wait_cnt_r <= '0;
                        pend_r     <= 1'b0;
                        if (redirect_s) begin
                            // Stale word is dropped; the access restarts at the new PC.
                            pc_r      <= redirect_pc_s;
                            imem_addr <= redirect_pc_s;
                        end else begin
                            instruction <= imem_rdata;
                            instr_pc    <= pc_r;
                            load_ir     <= 1'b1;
                            imem_req    <= 1'b0;
                            state_r     <= FETCH_DONE;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                        pend_r   <= 1'b0;
                        state_r  <= FETCH_FAULT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        if (pc_load) begin
                            pend_r    <= 1'b1;
                            pend_pc_r <= pc_target;
                        end
                    end
                end
                FETCH_DONE: begin
                    load_ir <= 1'b0;
                    if (bad_target_s) begin
                        fault   <= 1'b1;
                        state_r <= FETCH_FAULT;
                    end else if (pc_load) begin
                        pc_r    <= pc_target;
                        state_r <= FETCH_IDLE;
                    end else begin
                        pc_r    <= pc_r + PC_STEP;
                        state_r <= FETCH_IDLE;
                    end
                end
                FETCH_FAULT: begin
                    imem_req <= 1'b0;
                    load_ir  <= 1'b0;
                    fault    <= 1'b1;
                end
                default: begin
                    imem_req <= 1'b0;
                    load_ir  <= 1'b0;
                    fault    <= 1'b1;
                    state_r  <= FETCH_FAULT;
                end
            endcase
        end
    end

endmodule
